// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the write-back arbiter: register-file
// widths, the zero register and the arbiter state encoding.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int AGE_W  = 3;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        STALL = 2'd2
    } wb_arb_state_t;

endpackage : pipe_pkg

// File: rtl/wb_arbiter_if.sv
// Bundle of the MEM/WB write request, the mul/div result handshake and the
// register-file write port that meet at the write-back arbiter.
interface wb_arbiter_if;
    import pipe_pkg::*;

    logic              wr_regWr;
    logic              wr_memtoreg;
    logic [DATA_W-1:0] wr_dout;
    logic [DATA_W-1:0] wr_result;
    logic [REG_W-1:0]  wr_rw;

    logic              md_valid;
    logic [REG_W-1:0]  md_rw;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;

    logic              rf_we;
    logic [REG_W-1:0]  rf_rw;
    logic [DATA_W-1:0] rf_din;

    logic              pipe_stall;

    // Arbiter side.
    modport slave (
        input  wr_regWr, wr_memtoreg, wr_dout, wr_result, wr_rw,
        input  md_valid, md_rw, md_data,
        output md_ready,
        output rf_we, rf_rw, rf_din,
        output pipe_stall
    );

    // Pipeline / mul-div / register-file side.
    modport master (
        output wr_regWr, wr_memtoreg, wr_dout, wr_result, wr_rw,
        output md_valid, md_rw, md_data,
        input  md_ready,
        input  rf_we, rf_rw, rf_din,
        input  pipe_stall
    );

endinterface : wb_arbiter_if

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline first, mul/div results parked in a
// one-entry buffer, stall request on starvation. Option: WB_ARB_WAW_DROP_EN.
module wb_arbiter
    import pipe_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4   // legal 1..7, fits the age counter
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    localparam logic [AGE_W-1:0] STARVE_LIM = AGE_W'(STARVE_MAX);

    wb_arb_state_t     r_state;
    wb_arb_state_t     w_state_nxt;
    logic [AGE_W-1:0]  r_age;
    logic [AGE_W-1:0]  w_age_nxt;
    logic [REG_W-1:0]  r_buf_rw;
    logic [DATA_W-1:0] r_buf_data;

    logic w_pipe_wr;
    logic w_md_wr;
    logic w_capture;
    logic w_release;
    logic w_waw_hit;

    assign w_pipe_wr = bus.wr_regWr & (bus.wr_rw != REG_ZERO);
    assign w_md_wr   = bus.md_valid & (bus.md_rw != REG_ZERO);

`ifdef WB_ARB_WAW_DROP_EN
    // A younger pipeline write to the buffered register makes the parked result dead.
    assign w_waw_hit = w_pipe_wr & (r_state != IDLE) & (bus.wr_rw == r_buf_rw);
`else
    assign w_waw_hit = 1'b0;
`endif

    // The buffer empties either by draining into a free slot or by a WAW drop.
    assign w_release = !w_pipe_wr || w_waw_hit;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_age_nxt   = r_age;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_md_wr && w_pipe_wr) begin
                    w_capture   = 1'b1;
                    w_age_nxt   = '0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_release) begin
                    w_age_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_age_nxt = r_age + 1'b1;
                    if (r_age + 1'b1 == STARVE_LIM) begin
                        w_state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                if (w_release) begin
                    w_age_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_age_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_age   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_age   <= w_age_nxt;
        end
    end

    // NOTE: payload registers are not reset; their validity is carried entirely by r_state.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf_rw   <= bus.md_rw;
            r_buf_data <= bus.md_data;
        end
    end

    always_comb begin
        bus.rf_we      = 1'b0;
        bus.rf_rw      = REG_ZERO;
        bus.rf_din     = '0;
        bus.md_ready   = rst_n & (r_state == IDLE);
        bus.pipe_stall = rst_n & (r_state == STALL);
        if (rst_n) begin
            if (w_pipe_wr) begin
                bus.rf_we  = 1'b1;
                bus.rf_rw  = bus.wr_rw;
                bus.rf_din = bus.wr_memtoreg ? bus.wr_dout : bus.wr_result;
            end else if (r_state != IDLE) begin
                bus.rf_we  = 1'b1;
                bus.rf_rw  = r_buf_rw;
                bus.rf_din = r_buf_data;
            end else if (w_md_wr) begin
                bus.rf_we  = 1'b1;
                bus.rf_rw  = bus.md_rw;
                bus.rf_din = bus.md_data;
            end
        end
    end

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a table of per-cycle vectors fed through
// an expectation queue, plus a hand-written worst-case starvation sequence.
module tb_wb_arbiter;

    localparam int unsigned SM = 4;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        regwr;
        logic        m2r;
        logic [31:0] wdata;
        logic [4:0]  wrw;
        logic        mdv;
        logic [4:0]  mdrw;
        logic [31:0] mdd;
        logic        e_we;
        logic [4:0]  e_rw;
        logic [31:0] e_din;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    vec_t tbl[$];
    vec_t sb[$];

    wb_arbiter_if u_if ();

    wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // The unselected load/ALU source carries the complement so a wrong mux pick shows.
    task automatic drive(input logic rn, input logic regwr, input logic m2r,
                         input logic [31:0] wdata, input logic [4:0] wrw,
                         input logic mdv, input logic [4:0] mdrw, input logic [31:0] mdd);
        rst_n              = rn;
        u_if.wr_regWr      = regwr;
        u_if.wr_memtoreg   = m2r;
        u_if.wr_dout       = m2r ? wdata : ~wdata;
        u_if.wr_result     = m2r ? ~wdata : wdata;
        u_if.wr_rw         = wrw;
        u_if.md_valid      = mdv;
        u_if.md_rw         = mdrw;
        u_if.md_data       = mdd;
    endtask

    function automatic vec_t v(string nm, logic rn, logic regwr, logic m2r, logic [31:0] wdata,
                               logic [4:0] wrw, logic mdv, logic [4:0] mdrw, logic [31:0] mdd,
                               logic ewe, logic [4:0] erw, logic [31:0] edin,
                               logic erdy, logic estl);
        vec_t r;
        r.name = nm; r.rst_n = rn; r.regwr = regwr; r.m2r = m2r; r.wdata = wdata;
        r.wrw = wrw; r.mdv = mdv; r.mdrw = mdrw; r.mdd = mdd;
        r.e_we = ewe; r.e_rw = erw; r.e_din = edin; r.e_rdy = erdy; r.e_stall = estl;
        return r;
    endfunction

    initial begin
        vec_t e;
        int   stall_cyc;
        int   wr_lat;

        //             name             rst wr m2r wdata        wrw  mdv mdrw mdd          we rw   din          rdy stl
        tbl.push_back(v("reset_hold",    0, 1, 1, 32'h0000_0011, 5'd3, 1, 5'd5, 32'h0000_0022, 0, 5'd0, 32'h0,        0, 0));
        tbl.push_back(v("md_uncontested",1, 0, 0, 32'h0,         5'd0, 1, 5'd5, 32'h0000_1234, 1, 5'd5, 32'h0000_1234,1, 0));
        tbl.push_back(v("pipe_alu",      1, 1, 0, 32'h0000_BEEF, 5'd4, 0, 5'd0, 32'h0,         1, 5'd4, 32'h0000_BEEF,1, 0));
        tbl.push_back(v("pipe_r0",       1, 1, 1, 32'h0000_0ABC, 5'd0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,        1, 0));
        tbl.push_back(v("md_r0",         1, 0, 0, 32'h0,         5'd0, 1, 5'd0, 32'h0000_0FED, 0, 5'd0, 32'h0,        1, 0));
        tbl.push_back(v("contend_load",  1, 1, 1, 32'h0000_00AA, 5'd3, 1, 5'd7, 32'h0000_7777, 1, 5'd3, 32'h0000_00AA,1, 0));
        tbl.push_back(v("drain_hold",    1, 0, 0, 32'h0,         5'd0, 0, 5'd0, 32'h0,         1, 5'd7, 32'h0000_7777,0, 0));
        tbl.push_back(v("idle_quiet",    1, 0, 0, 32'h0,         5'd0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,        1, 0));
        tbl.push_back(v("starve_accept", 1, 1, 0, 32'h0000_0010, 5'd2, 1, 5'd12,32'h0000_C0DE, 1, 5'd2, 32'h0000_0010,1, 0));
        tbl.push_back(v("starve_1",      1, 1, 0, 32'h0000_0011, 5'd2, 1, 5'd13,32'h0000_D00D, 1, 5'd2, 32'h0000_0011,0, 0));
        tbl.push_back(v("starve_2",      1, 1, 0, 32'h0000_0012, 5'd2, 1, 5'd13,32'h0000_D00D, 1, 5'd2, 32'h0000_0012,0, 0));
        tbl.push_back(v("starve_3",      1, 1, 0, 32'h0000_0013, 5'd2, 1, 5'd13,32'h0000_D00D, 1, 5'd2, 32'h0000_0013,0, 0));
        tbl.push_back(v("starve_4",      1, 1, 0, 32'h0000_0014, 5'd2, 1, 5'd13,32'h0000_D00D, 1, 5'd2, 32'h0000_0014,0, 0));
        tbl.push_back(v("stall_on",      1, 1, 0, 32'h0000_0015, 5'd2, 1, 5'd13,32'h0000_D00D, 1, 5'd2, 32'h0000_0015,0, 1));
        tbl.push_back(v("stall_bubble",  1, 0, 0, 32'h0,         5'd0, 1, 5'd13,32'h0000_D00D, 1, 5'd12,32'h0000_C0DE,0, 1));
        tbl.push_back(v("stall_off",     1, 0, 0, 32'h0,         5'd0, 1, 5'd13,32'h0000_D00D, 1, 5'd13,32'h0000_D00D,1, 0));
        tbl.push_back(v("waw_accept",    1, 1, 0, 32'h0000_0020, 5'd8, 1, 5'd9, 32'h0000_9999, 1, 5'd8, 32'h0000_0020,1, 0));
        tbl.push_back(v("waw_pipe_r9",   1, 1, 0, 32'h0000_0055, 5'd9, 0, 5'd0, 32'h0,         1, 5'd9, 32'h0000_0055,0, 0));
`ifdef WB_ARB_WAW_DROP_EN
        tbl.push_back(v("waw_dropped",   1, 0, 0, 32'h0,         5'd0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,        1, 0));
`else
        tbl.push_back(v("waw_late_drain",1, 0, 0, 32'h0,         5'd0, 0, 5'd0, 32'h0,         1, 5'd9, 32'h0000_9999,0, 0));
`endif
        tbl.push_back(v("waw_idle",      1, 0, 0, 32'h0,         5'd0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,        1, 0));
        tbl.push_back(v("rst_accept",    1, 1, 0, 32'h0000_0030, 5'd1, 1, 5'd6, 32'h0000_6666, 1, 5'd1, 32'h0000_0030,1, 0));
        for (int i = 1; i <= 4; i++) begin
            tbl.push_back(v($sformatf("rst_starve_%0d", i), 1, 1, 0, 32'h0000_0030 + 32'(i), 5'd1,
                            0, 5'd0, 32'h0, 1, 5'd1, 32'h0000_0030 + 32'(i), 0, 0));
        end
        tbl.push_back(v("rst_in_stall",  1, 1, 0, 32'h0000_0035, 5'd1, 0, 5'd0, 32'h0,         1, 5'd1, 32'h0000_0035,0, 1));
        tbl.push_back(v("rst_low",       0, 1, 0, 32'h0000_0036, 5'd1, 1, 5'd6, 32'h0000_6667, 0, 5'd0, 32'h0,        0, 0));
        tbl.push_back(v("rst_released",  1, 0, 0, 32'h0,         5'd0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,        1, 0));
        tbl.push_back(v("rst_md_again",  1, 0, 0, 32'h0,         5'd0, 1, 5'd6, 32'h0000_6667, 1, 5'd6, 32'h0000_6667,1, 0));

        drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst_n, tbl[i].regwr, tbl[i].m2r, tbl[i].wdata, tbl[i].wrw,
                  tbl[i].mdv, tbl[i].mdrw, tbl[i].mdd);
            sb.push_back(tbl[i]);
            #2;
            e = sb.pop_front();
            check({e.name, ".rf_we"},      32'(u_if.rf_we),      32'(e.e_we));
            check({e.name, ".md_ready"},   32'(u_if.md_ready),   32'(e.e_rdy));
            check({e.name, ".pipe_stall"}, 32'(u_if.pipe_stall), 32'(e.e_stall));
            if (e.e_we) begin
                check({e.name, ".rf_rw"},  32'(u_if.rf_rw), 32'(e.e_rw));
                check({e.name, ".rf_din"}, u_if.rf_din,     e.e_din);
            end
        end

        // Worst-case starvation: accept under contention, keep the pipeline writing.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 5'd10, 1'b1, 5'd11, 32'h0000_ABCD);
        #2;
        check("worst.accept", 32'(u_if.md_ready), 32'd1);
        stall_cyc = 0;
        for (int c = 1; c <= 20 && stall_cyc == 0; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 32'h0000_0100 + 32'(c), 5'd10, 1'b0, 5'd0, 32'h0);
            #2;
            if (u_if.pipe_stall === 1'b1) stall_cyc = c;
        end
        check("worst.stall_cycle", 32'(stall_cyc), 32'(SM + 1));

        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0);
        #2;
        wr_lat = (u_if.rf_we === 1'b1 && u_if.rf_rw === 5'd11) ? stall_cyc + 1 : 0;
        check("worst.latency",    32'(wr_lat),            32'(SM + 2));
        check("worst.drain_data", u_if.rf_din,            32'h0000_ABCD);
        check("worst.stall_held", 32'(u_if.pipe_stall),   32'd1);

        @(negedge clk);
        #2;
        check("worst.stall_drop", 32'(u_if.pipe_stall),   32'd0);
        check("worst.ready_back", 32'(u_if.md_ready),     32'd1);
        check("worst.no_rewrite", 32'(u_if.rf_we),        32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wb_arbiter

// File: doc/wb_arbiter.md
# wb_arbiter

Arbiter for the register-file write port shared by the MEM/WB pipeline register and the multi-cycle multiply/divide unit. Sits between the MEM/WB stage outputs, the mul/div result interface, and the register file write port. The pipeline always has priority. A blocked mul/div result is parked in a one-entry holding buffer. If that result is starved for too long, the block requests a pipeline stall so that a bubble reaches WB and frees a write slot.

## Interface
Parameters:
- STARVE_MAX, 4: number of consecutive blocked cycles in HOLD before a stall is requested; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- wr_regWr  in  1  MEM/WB stage register-write enable
- wr_memtoreg  in  1  selects wr_dout (1) or wr_result (0)
- wr_dout  in  32  load data from MEM/WB
- wr_result  in  32  ALU result from MEM/WB
- wr_rw  in  5  destination register from MEM/WB
- md_valid  in  1  mul/div result valid
- md_rw  in  5  mul/div destination register
- md_data  in  32  mul/div result
- md_ready  out  1  mul/div result accepted this cycle when md_valid is also high
- rf_we  out  1  register-file write enable
- rf_rw  out  5  register-file write address
- rf_din  out  32  register-file write data
- pipe_stall  out  1  stall request: IF..MEM hold, and MEM/WB loads a bubble (regWr=0) at the next edge

## Operation
- pipe_wr = wr_regWr & (wr_rw != 0). Writes to r0 are never issued.
- States: IDLE (buffer empty), HOLD (buffer full, age counting), STALL (buffer full, pipe_stall=1).
- Write-port priority:
  - pipe_wr: rf_* come from the pipeline; rf_din = wr_memtoreg ? wr_dout : wr_result.
  - Else, state != IDLE: rf_* come from the buffer, and the buffer drains.
  - Else, md_valid & md_rw != 0: rf_* come directly from md_*.
- md_ready = (state == IDLE) & rst_n.
- IDLE, md_valid, pipe_wr: capture md_rw/md_data into the buffer; age <= 0; next state HOLD.
- IDLE, md_valid, md_rw == 0: handshake completes and the result is discarded; no write.
- HOLD, !pipe_wr: buffer drains; next state IDLE.
- HOLD, pipe_wr: age <= age+1; if age+1 == STARVE_MAX, next state STALL.
- STALL: pipe_stall = 1. On the first cycle with !pipe_wr the buffer drains; next state IDLE.
- rf_* outputs are combinational. buffer, age and state are registered.
- pipe_stall decodes the registered state. It deasserts the cycle after the drain.

## Timing
- Pipeline write latency is 0: rf_we is asserted in the same cycle as wr_regWr.
- mul/div latency:
  - 0 cycles when uncontested.
  - Otherwise written on the first free WB slot.
  - Worst case STARVE_MAX + 2 cycles after acceptance: STARVE_MAX blocked cycles, then stall asserted, then one bubble arrives.
- Reset (rst_n low at an edge): state IDLE, buffer invalid, age 0. While rst_n is low, rf_we=0, md_ready=0 and pipe_stall=0, regardless of inputs.
- A pending buffered result is lost on reset. Reset mid-STALL drops pipe_stall in the next cycle.
- A simultaneous pipe_wr and drain opportunity cannot occur; the pipeline always wins.
- md_valid while in HOLD/STALL: md_ready=0, and the mul/div unit holds its result.

## Configuration
- WB_ARB_WAW_DROP_EN defined: in HOLD/STALL, a pipe_wr with wr_rw == buffered rw clears the buffer. The next state is IDLE, age returns to 0, and no buffered write is issued. The younger pipeline write stands.
- Not defined: no comparison is made, and the buffered result drains normally on the next free slot.

## Structure
- Shared package pipe_pkg holds:
  - REG_ZERO (5'd0).
  - The wb_arb_state_t encoding (IDLE=2'd0, HOLD=2'd1, STALL=2'd2).
  - The 32-bit data-width constant.
- Single module. No sub-module; the holding buffer is two registers plus a valid implied by the state.

## Test plan
- Uncontested mul/div: IDLE, md_valid=1, md_rw=5, md_data=0x1234, wr_regWr=0 -> same cycle rf_we=1, rf_rw=5, rf_din=0x1234, md_ready=1; state stays IDLE.
- Contention then drain: md_rw=7 accepted while wr_regWr=1, wr_rw=3, wr_memtoreg=1, wr_dout=0xAA -> rf_din=0xAA and state HOLD. The next cycle with wr_regWr=0 gives rf_rw=7 with the md data; state returns to IDLE.
- Starvation, STARVE_MAX=4: buffer full, pipe_wr on 4 consecutive cycles -> pipe_stall=1 from cycle 5. A bubble arrives, the buffer drains, and pipe_stall=0 the following cycle.
- WAW with WB_ARB_WAW_DROP_EN: buffered rw=9, pipe writes rw=9 value 0x55 -> rf_din=0x55 and state IDLE; no later write to r9. Without the macro, r9 receives the buffered value at the next free slot.
- r0 suppression: wr_regWr=1, wr_rw=0 -> rf_we=0. md_valid with md_rw=0 -> md_ready=1, rf_we=0.
- Reset mid-STALL: rst_n=0 for one edge -> pipe_stall=0, md_ready=0, rf_we=0 while low. After release, state IDLE and md_ready=1.
